// File: rtl/uart_tx_arbiter_if.sv
// Purpose: bundles the requester streams, the registered bridge stream and the arbiter status.
// Latency: none; this file only carries the signals between the arbiter and its neighbours.
// Backpressure: req_tready is driven by the arbiter; out_tready is driven by the UART bridge.
//
// Signals:
//   req_tvalid/req_tdata/req_tlast : NUM_REQ AXI-stream requesters; requester i owns
//                                    req_tdata[i*DATA_WIDTH +: DATA_WIDTH]
//   req_tready                     : per-requester ready, at most one bit high
//   out_tvalid/out_tdata/out_tlast : registered stream toward the UART TX bridge
//   out_tready                     : bridge ready (UART TX not busy)
//   grant/busy/timeout             : one-hot owner, locked flag, watchdog pulse
// Modports: master = arbiter side, slave = requesters plus bridge side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_tvalid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata;
  logic [NUM_REQ-1:0]            req_tlast;
  logic [NUM_REQ-1:0]            req_tready;
  logic                          out_tvalid;
  logic [DATA_WIDTH-1:0]         out_tdata;
  logic                          out_tlast;
  logic                          out_tready;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          timeout;

  modport master (
    input  req_tvalid, req_tdata, req_tlast, out_tready,
    output req_tready, out_tvalid, out_tdata, out_tlast, grant, busy, timeout
  );

  modport slave (
    output req_tvalid, req_tdata, req_tlast, out_tready,
    input  req_tready, out_tvalid, out_tdata, out_tlast, grant, busy, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin, frame-locked arbiter sharing one UART TX byte stream among NUM_REQ requesters.
// Latency: grant one cycle after request; accepted beat appears on out_* the next cycle.
// Backpressure: single-entry output register; granted ready = !out_tvalid || out_tready.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : uart_tx_arbiter_if.master (requester streams, output stream, grant/busy/timeout)
// Parameters: NUM_REQ (2..8), DATA_WIDTH, TIMEOUT_CYCLES (2..65535, watchdog only).
// Optional feature: define UART_ARB_TIMEOUT_EN to build the stall watchdog; without it
// timeout is tied low and a grant is released only by a transferred tlast beat.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // State registers
  logic [0:0]            r_state;
  logic [IDX_W-1:0]      r_grant_idx;
  logic [NUM_REQ-1:0]    r_grant;
  logic [IDX_W-1:0]      r_last_grant;

  // Output register
  logic                  r_out_tvalid;
  logic [DATA_WIDTH-1:0] r_out_tdata;
  logic                  r_out_tlast;

  // Combinational helpers
  logic [NUM_REQ-1:0]    w_mask_hi;
  logic [NUM_REQ-1:0]    w_req_hi;
  logic                  w_any_req;
  logic                  w_any_hi;
  logic [IDX_W-1:0]      w_sel_hi;
  logic [IDX_W-1:0]      w_sel_lo;
  logic [IDX_W-1:0]      w_sel_idx;
  logic                  w_gnt_vld;
  logic [DATA_WIDTH-1:0] w_gnt_tdata;
  logic                  w_gnt_tlast;
  logic                  w_out_free;
  logic                  w_xfer;
  logic                  w_wd_fire;
  logic                  w_release;

  // ---------------------------------------------------------------------------
  // Round-robin selection: requesters above last_grant win first; if none of
  // them is valid, the lowest valid index wins (the wrap-around part).
  // ---------------------------------------------------------------------------
  always_comb begin
    w_mask_hi = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask_hi[i] = (IDX_W'(i) > r_last_grant);
    end
  end

  assign w_req_hi  = bus.req_tvalid & w_mask_hi;
  assign w_any_req = |bus.req_tvalid;
  assign w_any_hi  = |w_req_hi;

  // Descending scans so the lowest set index is the one that sticks.
  always_comb begin
    w_sel_hi = '0;
    w_sel_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_hi[i]) begin
        w_sel_hi = IDX_W'(i);
      end
      if (bus.req_tvalid[i]) begin
        w_sel_lo = IDX_W'(i);
      end
    end
  end

  assign w_sel_idx = w_any_hi ? w_sel_hi : w_sel_lo;

  // ---------------------------------------------------------------------------
  // Granted-requester mux. r_grant is zero in IDLE, so w_gnt_vld is too.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_gnt_vld   = 1'b0;
    w_gnt_tdata = '0;
    w_gnt_tlast = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_gnt_vld   = bus.req_tvalid[i];
        w_gnt_tdata = bus.req_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_gnt_tlast = bus.req_tlast[i];
      end
    end
  end

  // The output register can take a beat when empty or draining this cycle.
  assign w_out_free = !r_out_tvalid || bus.out_tready;
  assign w_xfer     = (r_state == ST_LOCKED) && w_gnt_vld && w_out_free;
  assign w_release  = (w_xfer && w_gnt_tlast) || w_wd_fire;

  assign bus.req_tready = (r_state == ST_LOCKED) ? (r_grant & {NUM_REQ{w_out_free}})
                                                 : '0;
  assign bus.grant      = r_grant;
  assign bus.busy       = (r_state == ST_LOCKED);
  assign bus.out_tvalid = r_out_tvalid;
  assign bus.out_tdata  = r_out_tdata;
  assign bus.out_tlast  = r_out_tlast;

  // ---------------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_grant_idx  <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state     <= ST_LOCKED;
            r_grant     <= NUM_REQ'(1) << w_sel_idx;
            r_grant_idx <= w_sel_idx;
          end
        end
        ST_LOCKED: begin
          // The grant survives tvalid gaps; only tlast or the watchdog ends it.
          if (w_release) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= r_grant_idx;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Single-entry output register. Load wins over drain so a simultaneous
  // drain+load gives back-to-back beats; it keeps draining after IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_tvalid <= 1'b0;
      r_out_tdata  <= '0;
      r_out_tlast  <= 1'b0;
    end else if (w_xfer) begin
      r_out_tvalid <= 1'b1;
      r_out_tdata  <= w_gnt_tdata;
      r_out_tlast  <= w_gnt_tlast;
    end else if (bus.out_tready) begin
      r_out_tvalid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall watchdog
  // ---------------------------------------------------------------------------
`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wd_cnt;
  logic        r_timeout;

  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle; the release and
  // the timeout pulse both land on the following cycle.
  assign w_wd_fire = (r_state == ST_LOCKED) && !w_gnt_vld && (r_wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_wd_fire;
      // Held at zero outside LOCKED, so entering LOCKED starts from zero.
      if ((r_state != ST_LOCKED) || w_xfer || w_wd_fire) begin
        r_wd_cnt <= '0;
      end else if (!w_gnt_vld) begin
        r_wd_cnt <= r_wd_cnt + 16'd1;
      end
    end
  end

  assign bus.timeout = r_timeout;
`else
  logic w_unused_timeout_cfg;

  assign w_wd_fire            = 1'b0;
  assign bus.timeout          = 1'b0;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit byte stream among `NUM_REQ` AXI-stream requesters, e.g. the command responder, the debug/status reporter and the event logger. It grants one requester at a time and holds the grant for a whole frame, through the accepted beat with `tlast`. Its registered output feeds the TX slave port of the UART AXI bridge. An optional watchdog reclaims the grant from a requester that stalls mid-frame.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters, legal range 2..8.
- `DATA_WIDTH`, 8: byte width per beat.
- `TIMEOUT_CYCLES`, 1024: stall limit for the watchdog, legal range 2..65535; used only with the macro.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_tvalid`  in  NUM_REQ  per-requester valid.
- `req_tdata`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_tlast`  in  NUM_REQ  last byte of the frame.
- `req_tready`  out  NUM_REQ  per-requester ready; at most one bit high.
- `out_tvalid`  out  1  registered valid toward the bridge.
- `out_tdata`  out  DATA_WIDTH  registered byte.
- `out_tlast`  out  1  registered last flag.
- `out_tready`  in  1  ready from the bridge (high when UART TX is not busy).
- `grant`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `busy`  out  1  high while in LOCKED.
- `timeout`  out  1  one-cycle pulse when the watchdog fires; tied 0 when the watchdog is compiled out.

## Operation
State machine, two states:

IDLE
- `req_tready` = 0.
- If any `req_tvalid` is high, select the first requester with valid high, searching upward from `last_grant+1` and wrapping modulo `NUM_REQ`.
- Next cycle: LOCKED, with `grant` set to that requester.
- Otherwise stay in IDLE.

LOCKED
- `req_tready[g]` = `!out_tvalid || out_tready`. All other ready bits are 0.
- A beat transfers when `req_tvalid[g] && req_tready[g]`. The output register loads `tdata`/`tlast` and sets `out_tvalid`.
- If the transferred beat has `tlast`=1, go to IDLE and set `last_grant` = g.

Output register (single entry):
- `out_tvalid` clears on `out_tready` unless a new beat loads in the same cycle. A simultaneous drain and load yields back-to-back beats with no bubble.
- The data registers hold their value while `out_tvalid && !out_tready`.
- The output register continues to drain independently after the return to IDLE.

Other rules:
- Requesters deasserting `tvalid` mid-frame keep the grant; no other requester is served until `tlast` transfers (or the watchdog fires).
- Grant index width is `$clog2(NUM_REQ)`. The round-robin pointer wraps from `NUM_REQ-1` to 0.

## Timing
- Reset values: `req_tready`=0, `out_tvalid`=0, `out_tdata`=0, `out_tlast`=0, `grant`=0, `busy`=0, `timeout`=0.
- Reset state: IDLE, `last_grant`=`NUM_REQ-1` (requester 0 has first priority), watchdog counter 0.
- Grant latency: `req_tvalid` high in cycle N (IDLE) gives `grant`/`busy` in N+1, and `req_tready` in N+1 if the output register is empty.
- Data latency: a beat accepted in cycle M appears on `out_*` in M+1.
- Frame turnaround: `tlast` accepted in cycle M puts the state in IDLE at M+1 and the next grant at M+2. This gives one dead arbitration cycle per frame.
- Reset asserted mid-frame: everything returns to reset values immediately. A partially sent frame is abandoned; the bench must not expect completion.
- Requests arriving while LOCKED wait; they are never dropped.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined: a 16-bit counter runs while in LOCKED with `req_tvalid[g]`=0.
  - The counter clears on any transferred beat and on entering LOCKED.
  - When it reaches `TIMEOUT_CYCLES`: pulse `timeout` for one cycle, go to IDLE, set `last_grant` = g, and clear the counter.
  - A byte already in the output register still drains.
- Not defined: no counter is instantiated, `timeout` is tied 0, and the grant is released only by `tlast`.

## Test plan
- Single frame: req0 sends 0x41, 0x42, 0x43 (`tlast` on 0x43), with `out_tready` held high. Required: the bridge sees 41 42 43 in consecutive cycles, `out_tlast` only on 43, then `busy`=0.
- Fairness: all three requesters are continuously valid with 1-byte frames (req i sends 0xA0+i). Required: output order A0 A1 A2 A0 A1 A2; `grant` bits are never high simultaneously.
- Backpressure: `out_tready` is low for 5 cycles while `out_tvalid`=1 with 0x55. Required: `out_tdata` holds 0x55, `req_tready[g]`=0, and no beat is lost or duplicated once ready rises.
- Frame lock: req1 stalls `tvalid` for 20 cycles mid-frame while req2 is valid. Required: `grant` stays on req1; req2 is served only after req1's `tlast`.
- Watchdog (`UART_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): req0 sends 1 byte without `tlast`, then stalls. Required: `timeout` pulses 8 cycles after the stall, then req1 is granted.
- Mid-frame reset: assert `rst` after 2 of 4 bytes. Required: all outputs go to reset values in the same cycle; after release, req0 wins first.
